store_rmw_unit: RTL
===================

Name: store_rmw_unit

Overview:
- Store-side counterpart to the load size/extension path: writes a byte, halfword or word from the datapath into a word-only data memory that has no byte enables.
- Sub-word stores (sb/sh) run a read-modify-write sequence: read the containing word, merge the selected lane(s), write the word back. Word stores (sw) write directly.
- Sits between the datapath store request and the data memory port. Decodes funct3 size codes and flags misaligned or illegal stores.

Parameters:
- ADDR_W, 32, width of the byte address from the datapath.
- WADDR_W, ADDR_W-2, width of the memory word address (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- st_valid  in  1  store request present.
- st_ready  out  1  unit can accept a request.
- st_addr  in  ADDR_W  byte address of store.
- st_data  in  32  store data; low byte or halfword used for sb/sh.
- st_size  in  3  funct3: 000 sb, 001 sh, 010 sw; all others illegal.
- st_done  out  1  one-cycle pulse: store committed.
- st_err  out  1  one-cycle pulse: store rejected (misaligned or illegal size).
- mem_addr  out  WADDR_W  word address (latched st_addr[ADDR_W-1:2]).
- mem_rd_en  out  1  memory read strobe.
- mem_rdata  in  32  read data, valid exactly 1 cycle after mem_rd_en.
- mem_wr_en  out  1  memory write strobe.
- mem_wdata  out  32  write data.

Behaviour:
- Reset (rst=1 at edge): state goes to IDLE and address, data and size registers clear to 0. While rst=1, st_ready, st_done, st_err, mem_rd_en and mem_wr_en are forced to 0. mem_addr and mem_wdata read 0 after reset.
- All outputs decode from registered state only, except the rst gating. There is no combinational path from st_* inputs to outputs.
- States: IDLE, READ, MERGE, WRITE, ERR.
- IDLE: st_ready=1. If st_valid=1, latch addr, data and size at the edge, then:
  - size 010 with addr[1:0]=00 -> WRITE.
  - size 000 (any address), or size 001 with addr[0]=0 -> READ.
  - anything else (sh with addr[0]=1, sw with addr[1:0]!=00, size not in {000,001,010}) -> ERR.
- READ: mem_rd_en=1 for one cycle -> MERGE.
- MERGE: capture mem_rdata and build the merged word into the write register -> WRITE.
  - Little-endian lane rules:
    - sb: lane k=addr[1:0]; bits [8k+7:8k] := st_data[7:0].
    - sh: addr[1]=0 -> [15:0] := st_data[15:0]; addr[1]=1 -> [31:16] := st_data[15:0].
    - Unselected bits keep the mem_rdata value.
- WRITE: mem_wr_en=1 and st_done=1 for one cycle; mem_wdata = merged word (sb/sh) or latched st_data (sw) -> IDLE.
- ERR: st_err=1 for one cycle; no memory strobe -> IDLE.
- Latency from the accept edge: sw, done in the next cycle. sb/sh, done 3 cycles later. Error, flagged in the next cycle.
- Throughput: st_ready=0 outside IDLE. st_valid is ignored while busy; the requester holds it until the accept cycle. Back-to-back requests: the next accept happens in the cycle after WRITE or ERR.
- mem_addr holds the latched word address from accept until the next accept.
- mem_rd_en and mem_wr_en are never both 1 in the same cycle.
- Reset mid-operation:
  - rst in READ, MERGE or WRITE abandons the store; no write is issued in or after the rst cycle.
  - A partially merged word is discarded.
  - No st_done or st_err is produced for the abandoned request.

Test Plan:
- sw addr 0x0000_0010, data 0xDEAD_BEEF -> cycle after accept: mem_wr_en=1, mem_addr=0x4, mem_wdata=0xDEAD_BEEF, st_done=1; mem_rd_en never asserted.
- sb addr 0x0000_0022, data 0x0000_00A5, mem returns 0x1122_3344 -> READ at mem_addr=0x8; WRITE mem_wdata=0x11A5_3344; st_done 3 cycles after accept.
- sh addr 0x0000_0006, data 0xFFFF_CAFE, mem returns 0x0102_0304 -> mem_wdata=0xCAFE_0304. Same with addr 0x4 -> 0x0102_CAFE.
- Errors: sh addr 0x0000_0003, sw addr 0x0000_0002, and size 011 -> st_err pulse in the cycle after accept; no mem_rd_en or mem_wr_en; st_ready=1 again the following cycle.
- st_valid held high with two queued stores (sb, then sw) -> second accepted in the cycle after the first WRITE; st_ready=0 during READ, MERGE and WRITE.
- rst=1 during MERGE of an sb -> no mem_wr_en and no st_done; after rst drops, st_ready=1 and a fresh sw completes normally.

Source files
------------

// File: rtl/store_rmw_unit.sv
// Store path into a word-only data memory: sw writes directly, sb/sh perform
// a read-modify-write of the containing word. Misaligned/illegal sizes are rejected.
module store_rmw_unit #(
  parameter int ADDR_W = 32,
  localparam int WADDR_W = ADDR_W - 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st_valid,
  output logic               st_ready,
  input  logic [ADDR_W-1:0]  st_addr,
  input  logic [31:0]        st_data,
  input  logic [2:0]         st_size,
  output logic               st_done,
  output logic               st_err,
  output logic [WADDR_W-1:0] mem_addr,
  output logic               mem_rd_en,
  input  logic [31:0]        mem_rdata,
  output logic               mem_wr_en,
  output logic [31:0]        mem_wdata
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, ERR} state_t;

  localparam logic [2:0] SZ_B = 3'b000;
  localparam logic [2:0] SZ_H = 3'b001;
  localparam logic [2:0] SZ_W = 3'b010;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [2:0]        size_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merged;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (st_valid) begin
          if (st_size == SZ_W && st_addr[1:0] == 2'b00)
            state_nx = WRITE;
          else if (st_size == SZ_B || (st_size == SZ_H && !st_addr[0]))
            state_nx = READ;
          else
            state_nx = ERR;
        end
      end
      READ:    state_nx = MERGE;
      MERGE:   state_nx = WRITE;
      WRITE:   state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Little-endian lane insert over the word just read back.
  always_comb begin
    merged = mem_rdata;
    if (size_q == SZ_H) begin
      if (addr_q[1]) merged[31:16] = data_q[15:0];
      else           merged[15:0]  = data_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = data_q[7:0];
        2'd1:    merged[15:8]  = data_q[7:0];
        2'd2:    merged[23:16] = data_q[7:0];
        default: merged[31:24] = data_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && st_valid) begin
        addr_q <= st_addr;
        data_q <= st_data;
        size_q <= st_size;
      end
      if (state == MERGE)
        wdata_q <= merged;
    end
  end

  assign st_ready  = !rst && (state == IDLE);
  assign mem_rd_en = !rst && (state == READ);
  assign mem_wr_en = !rst && (state == WRITE);
  assign st_done   = !rst && (state == WRITE);
  assign st_err    = !rst && (state == ERR);
  assign mem_addr  = addr_q[ADDR_W-1:2];
  assign mem_wdata = (size_q == SZ_W) ? data_q : wdata_q;

endmodule
